// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-to-1 arbitrating multiplexer with a valid/ready
// handshake and one registered output word. The arbiter is round-robin
// (PRIORITY_MODE=0) or fixed priority with the lowest index winning
// (PRIORITY_MODE=1).
module rr_arb_mux #(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH*DATA_W-1:0]   data_i,
  input  logic [NUM_CH-1:0]          valid_i,
  output logic [NUM_CH-1:0]          ready_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic [$clog2(NUM_CH)-1:0]  sel_o,
  input  logic                       ready_i
);

  localparam int CH_W = $clog2(NUM_CH);

  // Output register and round-robin pointer.
  logic [DATA_W-1:0] data_p1;
  logic [CH_W-1:0]   sel_p1;
  logic              vld_p1;
  logic [CH_W-1:0]   ptr;

  // Arbitration results for the current cycle.
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gnt_idx;
  logic              space;
  logic              xfer;
  logic [DATA_W-1:0] data_p0;
  logic [CH_W-1:0]   ptr_nxt;

  // ---- Stage p0: arbitration and input selection (combinational) ----

  // Search the channels starting from ptr (RR) or from 0 (fixed), wrapping
  // modulo NUM_CH; the first requesting channel wins. The running sum is one
  // bit wider than CH_W so the wrap works for non-power-of-two NUM_CH.
  always_comb begin
    logic [CH_W:0] base;
    logic [CH_W:0] idx;
    logic          found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    base    = (PRIORITY_MODE == 0) ? {1'b0, ptr} : '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = base + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) begin
        idx = idx - (CH_W+1)'(NUM_CH);
      end
      if (!found && valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx[CH_W-1:0];
      end
    end
  end

  // The output register can take a word when it is empty or being drained
  // this cycle; ready is held low during reset so no producer sees a
  // transfer that the register would then discard.
  always_comb begin
    space   = ~vld_p1 | ready_i;
    ready_o = grant & {NUM_CH{space & ~rst_i}};
    xfer    = |ready_o;
  end

  // Only the granted channel's slice is read, so unknown data on idle
  // channels never reaches the output register.
  always_comb begin
    data_p0 = data_i[gnt_idx*DATA_W +: DATA_W];
    ptr_nxt = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // ---- Stage p1: output register, pointer update ----

  // Load on transfer (also covers consume-and-load in one cycle), drain when
  // consumed with nothing new, otherwise hold. ptr only moves on a RR grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      sel_p1  <= gnt_idx;
      if (PRIORITY_MODE == 0) begin
        ptr <= ptr_nxt;
      end
    end else if (ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign data_o  = data_p1;
  assign valid_o = vld_p1;
  assign sel_o   = sel_p1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vectors for rr_arb_mux. One instance runs in
// round-robin mode, a second in fixed-priority mode; both use DATA_W=8,
// NUM_CH=4.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  // round-robin instance
  logic [31:0] r_data_i;
  logic [3:0]  r_valid_i;
  logic [3:0]  r_ready_o;
  logic [7:0]  r_data_o;
  logic        r_valid_o;
  logic [1:0]  r_sel_o;
  logic        r_ready_i;
  // fixed-priority instance
  logic [31:0] f_data_i;
  logic [3:0]  f_valid_i;
  logic [3:0]  f_ready_o;
  logic [7:0]  f_data_o;
  logic        f_valid_o;
  logic [1:0]  f_sel_o;
  logic        f_ready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.DATA_W(8), .NUM_CH(4), .PRIORITY_MODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .data_i(r_data_i), .valid_i(r_valid_i),
    .ready_o(r_ready_o), .data_o(r_data_o), .valid_o(r_valid_o),
    .sel_o(r_sel_o), .ready_i(r_ready_i)
  );

  rr_arb_mux #(.DATA_W(8), .NUM_CH(4), .PRIORITY_MODE(1)) u_fix (
    .clk_i(clk), .rst_i(rst), .data_i(f_data_i), .valid_i(f_valid_i),
    .ready_o(f_ready_o), .data_o(f_data_o), .valid_o(f_valid_o),
    .sel_o(f_sel_o), .ready_i(f_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r_data_i = 32'h0; r_valid_i = 4'b1111; r_ready_i = 1'b1;
    f_data_i = 32'h0; f_valid_i = 4'b1111; f_ready_i = 1'b1;
    #1;

    // Reset: two cycles with every request raised
    step(); step();
    chk("rst_ready_o", 32'(r_ready_o), 32'h0);
    chk("rst_valid_o", 32'(r_valid_o), 32'h0);
    chk("rst_data_o",  32'(r_data_o),  32'h00);
    chk("rst_sel_o",   32'(r_sel_o),   32'h0);
    chk("rst_f_ready", 32'(f_ready_o), 32'h0);
    chk("rst_f_valid", 32'(f_valid_o), 32'h0);

    rst = 1'b0; r_valid_i = 4'b0000; f_valid_i = 4'b0000;
    step();

    // Single request on ch2; other channels carry junk that must not leak
    r_data_i = {8'hEE, 8'hA5, 8'h77, 8'h33};
    r_valid_i = 4'b0100;
    #1;
    chk("single_ready_o", 32'(r_ready_o), 32'b0100);
    step();
    chk("single_valid_o", 32'(r_valid_o), 32'h1);
    chk("single_data_o",  32'(r_data_o),  32'hA5);
    chk("single_sel_o",   32'(r_sel_o),   32'h2);

    // Drain with no new requests; data/sel keep last values
    r_valid_i = 4'b0000;
    step();
    chk("drain_valid_o", 32'(r_valid_o), 32'h0);
    chk("drain_data_o",  32'(r_data_o),  32'hA5);
    chk("drain_sel_o",   32'(r_sel_o),   32'h2);
    step();
    // ptr was left at 3 by the ch2 grant and an idle cycle must not move it
    r_valid_i = 4'b1111;
    #1;
    chk("idle_ptr_grant", 32'(r_ready_o), 32'b1000);

    // Reset to bring ptr back to 0 before the rotation run
    rst = 1'b1;
    step();
    rst = 1'b0;

    // RR rotation at one word per cycle
    r_data_i = 32'h13121110;
    r_valid_i = 4'b1111;
    r_ready_i = 1'b1;
    #1;
    chk("rot_first_ready", 32'(r_ready_o), 32'b0001);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("rot_valid_o", 32'(r_valid_o), 32'h1);
      chk("rot_sel_o",   32'(r_sel_o),   32'(j % 4));
      chk("rot_data_o",  32'(r_data_o),  32'h10 + 32'(j % 4));
    end

    // Backpressure: ch1 word held for three cycles, no ready toward producers
    r_ready_i = 1'b0;
    #1;
    chk("bp_ready_o", 32'(r_ready_o), 32'b0000);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bp_valid_o", 32'(r_valid_o), 32'h1);
      chk("bp_data_o",  32'(r_data_o),  32'h11);
      chk("bp_sel_o",   32'(r_sel_o),   32'h1);
      chk("bp_ready_o_hold", 32'(r_ready_o), 32'b0000);
    end
    // Raising ready_i opens space in the same cycle: ch2 granted immediately
    r_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(r_ready_o), 32'b0100);
    step();
    chk("bp_release_sel",   32'(r_sel_o),   32'h2);
    chk("bp_release_data",  32'(r_data_o),  32'h12);
    chk("bp_release_valid", 32'(r_valid_o), 32'h1);

    // Mid-stream reset
    step();
    chk("mid_pre_sel", 32'(r_sel_o), 32'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(r_ready_o), 32'b0000);
    step();
    chk("mid_rst_valid", 32'(r_valid_o), 32'h0);
    chk("mid_rst_data",  32'(r_data_o),  32'h00);
    rst = 1'b0;
    #1;
    chk("mid_after_ready", 32'(r_ready_o), 32'b0001);
    step();
    chk("mid_after_sel",  32'(r_sel_o),  32'h0);
    chk("mid_after_data", 32'(r_data_o), 32'h10);

    // Fixed priority: ch1 wins over ch2/ch3, then ch0 wins every time
    r_valid_i = 4'b0000;
    f_data_i = 32'h23222120;
    f_valid_i = 4'b1110;
    f_ready_i = 1'b1;
    #1;
    chk("fix_ready_1110", 32'(f_ready_o), 32'b0010);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("fix_sel_1110",  32'(f_sel_o),  32'h1);
      chk("fix_data_1110", 32'(f_data_o), 32'h21);
    end
    f_valid_i = 4'b1111;
    #1;
    chk("fix_ready_1111", 32'(f_ready_o), 32'b0001);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("fix_sel_1111",   32'(f_sel_o),   32'h0);
      chk("fix_data_1111",  32'(f_data_o),  32'h20);
      chk("fix_valid_1111", 32'(f_valid_o), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
